// File: rtl/motor_act_stream_if.sv
// Stream bus for motor_act_stream: input beats in, activated beats out.
// Lane i occupies bits [i*DATA_W +: DATA_W] on both data buses.
interface motor_act_stream_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 18
) ();
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/motor_act_stream.sv
// Multi-lane streaming activation (ReLU / leaky / clipped / passthrough) for
// one layer vector, with one registered output stage and ap_* block control.
module motor_act_lane #(
  parameter int DATA_W      = 18,
  parameter int LEAKY_SHIFT = 3,
  parameter int CLIP_MAX    = 12288
) (
  input  logic        [1:0]        mode,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);
  localparam logic signed [DATA_W-1:0] CLIP = DATA_W'(CLIP_MAX);

  always_comb begin
    y = x;
    case (mode)
      2'd0: y = x[DATA_W-1] ? '0 : x;
      // >>> on a signed operand floors, so small negatives stay at -1
      2'd1: y = x[DATA_W-1] ? (x >>> LEAKY_SHIFT) : x;
      2'd2: begin
        if (x[DATA_W-1] || x == '0) y = '0;
        else if (x >= CLIP)         y = CLIP;
        else                        y = x;
      end
      default: y = x;
    endcase
  end
endmodule

module motor_act_stream #(
  parameter int DATA_W      = 18,
  parameter int N_ELEM      = 16,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3,
  parameter int CLIP_MAX    = 12288
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic                ap_idle,
  output logic                ap_done,
  input  logic [1:0]          mode,
  motor_act_stream_if.slave   s
);
  localparam int BEATS = N_ELEM / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              mode_q, mode_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic [LANES*DATA_W-1:0] act;
  logic                    in_ready, in_hs, out_hs, last_beat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    motor_act_lane #(
      .DATA_W(DATA_W), .LEAKY_SHIFT(LEAKY_SHIFT), .CLIP_MAX(CLIP_MAX)
    ) u_lane (
      .mode (mode_q),
      .x    (s.in_data[g*DATA_W +: DATA_W]),
      .y    (act[g*DATA_W +: DATA_W])
    );
  end

  // The output register frees up in the same cycle it is drained.
  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || s.out_ready);
  assign in_hs     = s.in_valid && in_ready;
  assign out_hs    = out_valid_q && s.out_ready;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ap_ready    = 1'b0;
    ap_idle     = 1'b0;
    ap_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          ap_ready = 1'b1;
          mode_d   = mode;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (out_hs) out_valid_d = 1'b0;
        if (in_hs) begin
          out_data_d  = act;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (last_beat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
endmodule

// File: tb/tb_motor_act_stream.sv
// Directed bench for motor_act_stream with hand-computed lane results.
module tb_motor_act_stream;
  logic       ap_clk = 1'b0;
  logic       ap_rst, ap_start, ap_ready, ap_idle, ap_done;
  logic [1:0] mode;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [71:0] vin[4];
  logic [71:0] vexp[4];
  logic [71:0] held;

  motor_act_stream_if #(.LANES(4), .DATA_W(18)) bus ();

  motor_act_stream dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .mode     (mode),
    .s        (bus.slave)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [71:0] pk(input int a, input int b, input int c, input int d);
    return {d[17:0], c[17:0], b[17:0], a[17:0]};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Full-rate 4-beat vector; optionally changes mode and holds ap_start mid-run.
  task automatic run_vec(input string tag, input logic [1:0] m,
                         input logic [1:0] mid_m, input logic mid_start);
    mode = m; ap_start = 1'b1; #1;
    chk({tag, "_ap_ready"}, ap_ready, 1);
    step();
    mode = mid_m; ap_start = mid_start; bus.out_ready = 1'b1;
    #1;
    chk({tag, "_idle_run"}, ap_idle, 0);
    for (int b = 0; b < 4; b++) begin
      bus.in_valid = 1'b1; bus.in_data = vin[b]; #1;
      chk($sformatf("%s_in_ready%0d", tag, b), bus.in_ready, 1);
      chk($sformatf("%s_no_rdy%0d", tag, b), ap_ready, 0);
      step();
      chk($sformatf("%s_data%0d", tag, b), bus.out_data, vexp[b]);
      chk($sformatf("%s_valid%0d", tag, b), bus.out_valid, 1);
      chk($sformatf("%s_early_done%0d", tag, b), ap_done, 0);
    end
    bus.in_valid = 1'b0; ap_start = 1'b0; #1;
    chk({tag, "_drain_in_ready"}, bus.in_ready, 0);
    step();
    chk({tag, "_done"}, ap_done, 1);
    chk({tag, "_done_valid"}, bus.out_valid, 0);
    step();
    chk({tag, "_done_pulse"}, ap_done, 0);
    chk({tag, "_back_idle"}, ap_idle, 1);
  endtask

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; mode = 2'd0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_ap_done", ap_done, 0);
    chk("rst_ap_ready", ap_ready, 0);
    chk("rst_ap_idle", ap_idle, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    ap_rst = 1'b0;
    step();

    // ReLU with backpressure on the first beat
    mode = 2'd0; ap_start = 1'b1; #1;
    chk("relu_ap_ready", ap_ready, 1);
    step();
    ap_start = 1'b0; #1;
    chk("relu_ready_pulse", ap_ready, 0);
    chk("relu_idle", ap_idle, 0);
    chk("relu_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = pk(-2048, 0, 1, 131071); bus.out_ready = 1'b0;
    step();
    chk("relu_b0_valid", bus.out_valid, 1);
    chk("relu_b0_data", bus.out_data, pk(0, 0, 1, 131071));
    held = bus.out_data;
    bus.in_data = pk(5, -5, 100, -100);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_in_ready%0d", c), bus.in_ready, 0);
      chk($sformatf("bp_stable%0d", c), bus.out_data, pk(0, 0, 1, 131071));
      chk($sformatf("bp_valid%0d", c), bus.out_valid, 1);
      step();
    end
    bus.out_ready = 1'b1; #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    step();
    chk("relu_b1_data", bus.out_data, pk(5, 0, 100, 0));
    bus.in_data = pk(-1, 2, -3, 4);
    step();
    chk("relu_b2_data", bus.out_data, pk(0, 2, 0, 4));
    bus.in_data = pk(131071, -131072, 7, 0);
    step();
    chk("relu_b3_data", bus.out_data, pk(131071, 0, 7, 0));
    chk("relu_b3_valid", bus.out_valid, 1);
    chk("relu_b3_nodone", ap_done, 0);
    bus.in_valid = 1'b0; #1;
    chk("relu_drain_in_ready", bus.in_ready, 0);
    step();
    chk("relu_done", ap_done, 1);
    step();
    chk("relu_done_once", ap_done, 0);
    chk("relu_idle_after", ap_idle, 1);

    // Leaky: floor division by 8
    vin[0] = pk(-2048, -1, -131072, 4096);  vexp[0] = pk(-256, -1, -16384, 4096);
    vin[1] = pk(-8, -9, 8, -7);             vexp[1] = pk(-1, -2, 8, -1);
    vin[2] = pk(131071, -16, -17, 1);       vexp[2] = pk(131071, -2, -3, 1);
    vin[3] = pk(0, -24, 24, -131071);       vexp[3] = pk(0, -3, 24, -16384);
    run_vec("leaky", 2'd1, 2'd1, 1'b0);

    // Clipped at 12288
    vin[0] = pk(20000, 12288, 12287, -5);    vexp[0] = pk(12288, 12288, 12287, 0);
    vin[1] = pk(0, 1, -131072, 131071);      vexp[1] = pk(0, 1, 0, 12288);
    vin[2] = pk(12289, -1, 6000, 131071);    vexp[2] = pk(12288, 0, 6000, 12288);
    vin[3] = pk(5, 12288, -12288, 12287);    vexp[3] = pk(5, 12288, 0, 12287);
    run_vec("clip", 2'd2, 2'd2, 1'b0);

    // ReLU latched at start; mode->clipped and ap_start mid-run are ignored
    vin[0] = pk(20000, -3, 131071, 0);       vexp[0] = pk(20000, 0, 131071, 0);
    vin[1] = pk(-20000, 12289, 1, -1);       vexp[1] = pk(0, 12289, 1, 0);
    vin[2] = pk(50000, 50000, -50000, 9);    vexp[2] = pk(50000, 50000, 0, 9);
    vin[3] = pk(-131072, 12288, 99999, -9);  vexp[3] = pk(0, 12288, 99999, 0);
    run_vec("modechg", 2'd0, 2'd2, 1'b1);

    // Passthrough, reset after beat 2
    mode = 2'd3; ap_start = 1'b1; step();
    ap_start = 1'b0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = pk(-5, 7, -131072, 131071);
    step();
    chk("pass_b0_data", bus.out_data, pk(-5, 7, -131072, 131071));
    bus.in_data = pk(-1, 0, 12345, -12345);
    step();
    chk("pass_b1_data", bus.out_data, pk(-1, 0, 12345, -12345));
    bus.in_valid = 1'b0; ap_rst = 1'b1;
    step();
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_idle", ap_idle, 1);
    chk("abort_done", ap_done, 0);
    chk("abort_data", bus.out_data, 0);
    ap_rst = 1'b0;
    step();
    chk("abort_no_done", ap_done, 0);
    chk("abort_in_ready", bus.in_ready, 0);

    vin[0] = pk(-2048, 0, 1, 131071);        vexp[0] = pk(0, 0, 1, 131071);
    vin[1] = pk(3, -3, 6, -6);               vexp[1] = pk(3, 0, 6, 0);
    vin[2] = pk(-100, 100, -1, 1);           vexp[2] = pk(0, 100, 0, 1);
    vin[3] = pk(77, -77, 131071, -131072);   vexp[3] = pk(77, 0, 131071, 0);
    run_vec("after_rst", 2'd0, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
